// File: rtl/fu_ls_unit_pkg.sv
// Shared types for the load/store functional unit: ops, FSM states, queue entry.
// The helper decides whether an entry completes with an error without touching memory.
package fu_ls_unit_pkg;
    localparam int GPR_SIZE     = 64;
    localparam int ROB_IDX_SIZE = 5;

    typedef enum logic [1:0] {
        FU_OP_NONE = 2'd0,
        FU_OP_LDUR = 2'd1,
        FU_OP_STUR = 2'd2
    } fu_op_t;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_REQ  = 2'd1,
        LS_RESP = 2'd2
    } ls_state_t;

    typedef struct packed {
        fu_op_t                  op;
        logic [GPR_SIZE-1:0]     addr;
        logic [GPR_SIZE-1:0]     wdata;
        logic [ROB_IDX_SIZE-1:0] dst;
    } ls_iq_entry_t;

    function automatic logic ls_entry_bad(input ls_iq_entry_t e);
        return (e.addr[2:0] != 3'd0) || !((e.op == FU_OP_LDUR) || (e.op == FU_OP_STUR));
    endfunction
endpackage

// File: rtl/fu_ls_iq.sv
// Input queue for the LS unit: push lands on the clock edge, head is visible combinationally.
// A push into a full queue succeeds only when a pop frees the slot in the same cycle.
module fu_ls_iq
    import fu_ls_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  ls_iq_entry_t             push_dat_i,
    input  logic                     pop_i,
    output ls_iq_entry_t             head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_nxt_o
);
    localparam int PW = $clog2(DEPTH);

    ls_iq_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        count_nxt_o = count_q;
        if (do_push && !do_pop) begin
            count_nxt_o = count_q + (PW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_nxt_o = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_nxt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/fu_ls_unit.sv
// Load/store FU: queues RS issues, runs each against memory via req/ack, holds completion until ROB accepts.
// Min start->done latency 3 cycles; misaligned/unknown ops and memory timeouts complete with error.
module fu_ls_unit
    import fu_ls_unit_pkg::*;
#(
    parameter int IQ_DEPTH    = 4,
    parameter int READY_SLACK = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_rs_start,
    input  fu_op_t                  in_rs_op,
    input  logic [GPR_SIZE-1:0]     in_rs_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
    output logic                    out_fu_ready,
    output logic                    out_mem_req,
    output logic                    out_mem_we,
    output logic [GPR_SIZE-1:0]     out_mem_addr,
    output logic [GPR_SIZE-1:0]     out_mem_wdata,
    input  logic                    in_mem_ack,
    input  logic [GPR_SIZE-1:0]     in_mem_rdata,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_error,
    input  logic                    in_rob_accept,
    output logic                    out_overflow
);
    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    ls_state_t           state_q, state_d;
    ls_iq_entry_t        cur_q, cur_d, head, push_dat;
    logic [GPR_SIZE-1:0] val_q, val_d;
    logic                err_q, err_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                ready_q, ready_d, ovf_q, ovf_d;
    logic                pop, take, iq_full, iq_empty;
    logic [CW-1:0]       count_nxt;

    assign push_dat = '{op: in_rs_op, addr: in_rs_val_a, wdata: in_rs_val_b, dst: in_rs_dst_rob_index};

    fu_ls_iq #(.DEPTH(IQ_DEPTH)) u_iq (
        .clk_i       (in_clk),
        .rst_ni      (in_rst),
        .push_i      (in_rs_start),
        .push_dat_i  (push_dat),
        .pop_i       (pop),
        .head_dat_o  (head),
        .full_o      (iq_full),
        .empty_o     (iq_empty),
        .count_nxt_o (count_nxt)
    );

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= LS_IDLE;
            cur_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            val_q   <= val_d;
            err_q   <= err_d;
            tmr_q   <= tmr_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        val_d   = val_q;
        err_d   = err_q;
        tmr_d   = tmr_q;
        take    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            LS_IDLE: take = !iq_empty;
            LS_REQ: begin
                tmr_d = tmr_q + TW'(1);
                if (in_mem_ack) begin
                    state_d = LS_RESP;
                    val_d   = (cur_q.op == FU_OP_LDUR) ? in_mem_rdata : '0;
                    err_d   = 1'b0;
                end else if (tmr_q == TW'(MEM_TIMEOUT - 1)) begin
                    state_d = LS_RESP;
                    val_d   = '0;
                    err_d   = 1'b1;
                end
            end
            LS_RESP: begin
                if (in_rob_accept) begin
                    state_d = LS_IDLE;
                    take    = !iq_empty;
                end
            end
            default: state_d = LS_IDLE;
        endcase
        // Popping from IDLE and from an accepted RESP share one decode so back-to-back ops lose no cycle.
        if (take) begin
            pop   = 1'b1;
            cur_d = head;
            tmr_d = '0;
            val_d = '0;
            if (ls_entry_bad(head)) begin
                state_d = LS_RESP;
                err_d   = 1'b1;
            end else begin
                state_d = LS_REQ;
                err_d   = 1'b0;
            end
        end
        ready_d = (IQ_DEPTH - int'(count_nxt)) > READY_SLACK;
        ovf_d   = ovf_q | (in_rs_start & iq_full & !pop);
    end

    always_comb begin
        out_mem_req           = 1'b0;
        out_mem_we            = 1'b0;
        out_mem_addr          = '0;
        out_mem_wdata         = '0;
        out_rob_done          = 1'b0;
        out_rob_dst_rob_index = '0;
        out_rob_value         = '0;
        out_rob_error         = 1'b0;
        case (state_q)
            LS_REQ: begin
                out_mem_req   = 1'b1;
                out_mem_we    = (cur_q.op == FU_OP_STUR);
                out_mem_addr  = cur_q.addr;
                out_mem_wdata = cur_q.wdata;
            end
            LS_RESP: begin
                out_rob_done          = 1'b1;
                out_rob_dst_rob_index = cur_q.dst;
                out_rob_value         = val_q;
                out_rob_error         = err_q;
            end
            default: ;
        endcase
    end

    assign out_fu_ready = ready_q;
    assign out_overflow = ovf_q;
endmodule

// File: tb/tb_fu_ls_unit.sv
// Directed bench for the LS unit: hand-computed expectations checked by immediate assertions.
module tb_fu_ls_unit;
    import fu_ls_unit_pkg::*;

    logic                    in_clk = 1'b0;
    logic                    in_rst = 1'b0;
    logic                    in_rs_start = 1'b0;
    fu_op_t                  in_rs_op = FU_OP_NONE;
    logic [GPR_SIZE-1:0]     in_rs_val_a = '0;
    logic [GPR_SIZE-1:0]     in_rs_val_b = '0;
    logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index = '0;
    logic                    out_fu_ready;
    logic                    out_mem_req;
    logic                    out_mem_we;
    logic [GPR_SIZE-1:0]     out_mem_addr;
    logic [GPR_SIZE-1:0]     out_mem_wdata;
    logic                    in_mem_ack = 1'b0;
    logic [GPR_SIZE-1:0]     in_mem_rdata = '0;
    logic                    out_rob_done;
    logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
    logic [GPR_SIZE-1:0]     out_rob_value;
    logic                    out_rob_error;
    logic                    in_rob_accept = 1'b0;
    logic                    out_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int req_cycles;

    fu_ls_unit dut (
        .in_clk                (in_clk),
        .in_rst                (in_rst),
        .in_rs_start           (in_rs_start),
        .in_rs_op              (in_rs_op),
        .in_rs_val_a           (in_rs_val_a),
        .in_rs_val_b           (in_rs_val_b),
        .in_rs_dst_rob_index   (in_rs_dst_rob_index),
        .out_fu_ready          (out_fu_ready),
        .out_mem_req           (out_mem_req),
        .out_mem_we            (out_mem_we),
        .out_mem_addr          (out_mem_addr),
        .out_mem_wdata         (out_mem_wdata),
        .in_mem_ack            (in_mem_ack),
        .in_mem_rdata          (in_mem_rdata),
        .out_rob_done          (out_rob_done),
        .out_rob_dst_rob_index (out_rob_dst_rob_index),
        .out_rob_value         (out_rob_value),
        .out_rob_error         (out_rob_error),
        .in_rob_accept         (in_rob_accept),
        .out_overflow          (out_overflow)
    );

    always #5 in_clk = ~in_clk;

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [ROB_IDX_SIZE-1:0] dst);
        in_rs_start         = 1'b1;
        in_rs_op            = op;
        in_rs_val_a         = a;
        in_rs_val_b         = b;
        in_rs_dst_rob_index = dst;
    endtask

    task automatic accept_once();
        in_rob_accept = 1'b1;
        step();
        in_rob_accept = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_ready", out_fu_ready, 0);
        chk("rst_req", out_mem_req, 0);
        chk("rst_done", out_rob_done, 0);
        chk("rst_ovf", out_overflow, 0);
        chk("rst_addr", out_mem_addr, 0);
        #10 in_rst = 1'b1;
        step();
        chk("ready_after_rst", out_fu_ready, 1);

        // LDUR 0x40, ack one cycle after req: done after 4 edges
        issue(FU_OP_LDUR, 64'h40, 64'h0, 5'd3);
        step();
        in_rs_start = 1'b0;
        chk("ld_idle_noreq", out_mem_req, 0);
        chk("ld_ready", out_fu_ready, 1);
        step();
        chk("ld_req", out_mem_req, 1);
        chk("ld_we", out_mem_we, 0);
        chk("ld_addr", out_mem_addr, 64'h40);
        step();
        chk("ld_req_held", out_mem_req, 1);
        in_mem_ack = 1'b1; in_mem_rdata = 64'h1234;
        step();
        in_mem_ack = 1'b0; in_mem_rdata = '0;
        chk("ld_done", out_rob_done, 1);
        chk("ld_value", out_rob_value, 64'h1234);
        chk("ld_dst", out_rob_dst_rob_index, 3);
        chk("ld_err", out_rob_error, 0);
        chk("ld_req_drop", out_mem_req, 0);
        step();
        chk("ld_done_held", out_rob_value, 64'h1234);
        accept_once();
        chk("ld_retired", out_rob_done, 0);

        // STUR 0x80 data 7
        issue(FU_OP_STUR, 64'h80, 64'h7, 5'd5);
        step();
        in_rs_start = 1'b0;
        step();
        chk("st_req", out_mem_req, 1);
        chk("st_we", out_mem_we, 1);
        chk("st_addr", out_mem_addr, 64'h80);
        chk("st_wdata", out_mem_wdata, 64'h7);
        step();
        chk("st_wdata_held", out_mem_wdata, 64'h7);
        in_mem_ack = 1'b1; in_mem_rdata = 64'hDEAD;
        step();
        in_mem_ack = 1'b0;
        chk("st_done", out_rob_done, 1);
        chk("st_value", out_rob_value, 0);
        chk("st_dst", out_rob_dst_rob_index, 5);
        accept_once();

        // Misaligned LDUR 0x43: error two edges after start, no memory access
        issue(FU_OP_LDUR, 64'h43, 64'h0, 5'd6);
        step();
        in_rs_start = 1'b0;
        chk("mis_noreq0", out_mem_req, 0);
        step();
        chk("mis_noreq1", out_mem_req, 0);
        chk("mis_done", out_rob_done, 1);
        chk("mis_err", out_rob_error, 1);
        chk("mis_value", out_rob_value, 0);
        accept_once();

        // Timeout: ack withheld, next queued STUR proceeds afterwards
        issue(FU_OP_LDUR, 64'h100, 64'h0, 5'd7);
        step();
        issue(FU_OP_STUR, 64'h108, 64'h9, 5'd8);
        step();
        in_rs_start = 1'b0;
        req_cycles = 0;
        while (out_mem_req && req_cycles < 40) begin
            req_cycles++;
            step();
        end
        chk("to_req_cycles", req_cycles, 16);
        chk("to_done", out_rob_done, 1);
        chk("to_err", out_rob_error, 1);
        chk("to_dst", out_rob_dst_rob_index, 7);
        accept_once();
        chk("to_next_req", out_mem_req, 1);
        chk("to_next_addr", out_mem_addr, 64'h108);
        chk("to_next_wdata", out_mem_wdata, 64'h9);
        in_mem_ack = 1'b1;
        step();
        in_mem_ack = 1'b0;
        chk("to_next_dst", out_rob_dst_rob_index, 8);
        chk("to_next_err", out_rob_error, 0);
        accept_once();

        // Overflow: one op stalled in REQ, then five back-to-back starts
        issue(FU_OP_LDUR, 64'h200, 64'h0, 5'd10);
        step();
        in_rs_start = 1'b0;
        step();
        chk("ov_head_req", out_mem_req, 1);
        for (int i = 0; i < 5; i++) begin
            issue(FU_OP_LDUR, 64'h208 + 64'(8 * i), 64'h0, 5'(11 + i));
            step();
            if (i == 0) chk("ov_ready_1", out_fu_ready, 1);
            if (i == 1) chk("ov_ready_2", out_fu_ready, 0);
            if (i == 3) chk("ov_ovf_4", out_overflow, 0);
        end
        in_rs_start = 1'b0;
        chk("ov_ovf_5", out_overflow, 1);
        in_mem_ack = 1'b1; in_mem_rdata = 64'hAA;
        step();
        in_mem_ack = 1'b0;
        chk("ov_head_value", out_rob_value, 64'hAA);
        chk("ov_head_dst", out_rob_dst_rob_index, 10);
        for (int i = 0; i < 4; i++) begin
            accept_once();
            chk($sformatf("ov_q%0d_addr", i), out_mem_addr, 64'h208 + 64'(8 * i));
            in_mem_ack = 1'b1; in_mem_rdata = 64'h100 + 64'(i);
            step();
            in_mem_ack = 1'b0;
            chk($sformatf("ov_q%0d_dst", i), out_rob_dst_rob_index, 64'(11 + i));
            chk($sformatf("ov_q%0d_value", i), out_rob_value, 64'h100 + 64'(i));
        end
        accept_once();
        step();
        chk("ov_drained_req", out_mem_req, 0);
        chk("ov_drained_done", out_rob_done, 0);
        chk("ov_ready_back", out_fu_ready, 1);
        chk("ov_sticky", out_overflow, 1);

        // Unknown op: error completion without memory access
        issue(fu_op_t'(2'd3), 64'h300, 64'h0, 5'd2);
        step();
        in_rs_start = 1'b0;
        step();
        chk("unk_noreq", out_mem_req, 0);
        chk("unk_err", out_rob_error, 1);
        chk("unk_dst", out_rob_dst_rob_index, 2);
        accept_once();

        // Reset asserted mid-REQ with a second entry queued
        issue(FU_OP_LDUR, 64'h400, 64'h0, 5'd1);
        step();
        issue(FU_OP_LDUR, 64'h408, 64'h0, 5'd4);
        step();
        in_rs_start = 1'b0;
        chk("rr_req_before", out_mem_req, 1);
        #2 in_rst = 1'b0;
        #1;
        chk("rr_req_async", out_mem_req, 0);
        chk("rr_done_async", out_rob_done, 0);
        chk("rr_ovf_clr", out_overflow, 0);
        chk("rr_ready_low", out_fu_ready, 0);
        #3 in_rst = 1'b1;
        step();
        chk("rr_ready_up", out_fu_ready, 1);
        step();
        step();
        chk("rr_queue_empty_req", out_mem_req, 0);
        chk("rr_queue_empty_done", out_rob_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
